// File: rtl/cfg_chain_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package cfg_chain_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Number of config words needed to cover a chain, last one possibly partial.
    function automatic int num_words(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/cfg_rb_packer.sv
// Serial-to-word packer for chain readback; flush closes a partial word left-aligned.
module cfg_rb_packer
    import cfg_chain_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              flush,
    input  logic              rb_ready,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);
    localparam int CW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WORD_W - 1);

    logic [WORD_W-2:0] sr_r;
    logic [CW-1:0]     cnt_r;
    logic [WORD_W-1:0] rb_data_r;
    logic              rb_valid_r;
    logic [WORD_W-1:0] word_s;
    logic [WORD_W-1:0] aligned_s;
    logic [CW-1:0]     pad_s;
    logic              complete_s;

    // Candidate word including the incoming bit, shifted up when closing a partial word.
    always_comb begin
        word_s     = {sr_r, bit_in};
        pad_s      = LAST_IDX - cnt_r;
        aligned_s  = word_s << pad_s;
        complete_s = bit_valid && ((cnt_r == LAST_IDX) || flush);
    end

    // Bit accumulation and output word hand-off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_r       <= '0;
            cnt_r      <= '0;
            rb_data_r  <= '0;
            rb_valid_r <= 1'b0;
        end else if (clr) begin
            sr_r       <= '0;
            cnt_r      <= '0;
            rb_valid_r <= 1'b0;
        end else begin
            if (bit_valid) begin
                sr_r <= word_s[WORD_W-2:0];
            end
            if (complete_s) begin
                cnt_r      <= '0;
                rb_data_r  <= aligned_s;
                rb_valid_r <= 1'b1;
            end else begin
                if (bit_valid) begin
                    cnt_r <= cnt_r + CW'(1);
                end
                if (rb_ready) begin
                    rb_valid_r <= 1'b0;
                end
            end
        end
    end

    assign rb_data  = rb_data_r;
    assign rb_valid = rb_valid_r;

endmodule

// File: rtl/cfg_chain_loader.sv
// Configuration-chain loader: serialises config words onto a tile's ccff chain
// and returns the displaced chain contents as readback words.
module cfg_chain_loader
    import cfg_chain_pkg::*;
#(
    parameter int CHAIN_LEN = 40,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              shift_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic              busy,
    output logic              done,
    output logic              aborted
);
    localparam int BW = $clog2(CHAIN_LEN + 1);
    localparam int IW = $clog2(WORD_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORD_W - 1);

    state_t            state_r;
    logic [WORD_W-1:0] buf_r;
    logic [BW-1:0]     bit_cnt_r;
    logic [IW-1:0]     idx_r;
    logic              done_r;
    logic              aborted_r;

    logic              busy_s;
    logic              kill_s;
    logic              rb_valid_s;
    logic              rb_stall_s;
    logic              last_bit_s;
    logic              word_end_s;
    logic              cfg_ready_s;
    logic              shift_en_s;
    logic              head_s;
    logic [WORD_W-1:0] rb_data_s;

    // Handshake and shift qualification; a shift that would close a readback
    // word while the previous one is still unconsumed is held back.
    always_comb begin
        busy_s      = (state_r != IDLE);
        kill_s      = busy_s && abort;
        rb_stall_s  = rb_valid_s && !rb_ready;
        last_bit_s  = (bit_cnt_r == LAST_BIT);
        word_end_s  = (idx_r == LAST_IDX) || last_bit_s;
        cfg_ready_s = (state_r == FETCH) && !kill_s && !rb_stall_s;
        shift_en_s  = (state_r == SHIFT) && !kill_s && !(word_end_s && rb_stall_s);
        if (state_r == SHIFT) begin
            head_s = buf_r[WORD_W-1];
        end else begin
            head_s = 1'b0;
        end
    end

    // Load sequencer: fetch a word, shift it out, repeat until the chain is full.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_r   <= IDLE;
            buf_r     <= '0;
            bit_cnt_r <= '0;
            idx_r     <= '0;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
            if (kill_s) begin
                state_r   <= IDLE;
                aborted_r <= 1'b1;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start && !abort) begin
                            state_r   <= FETCH;
                            bit_cnt_r <= '0;
                            idx_r     <= '0;
                        end
                    end
                    FETCH: begin
                        if (cfg_valid && cfg_ready_s) begin
                            buf_r   <= cfg_data;
                            idx_r   <= '0;
                            state_r <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (shift_en_s) begin
                            buf_r     <= {buf_r[WORD_W-2:0], 1'b0};
                            bit_cnt_r <= bit_cnt_r + BW'(1);
                            idx_r     <= idx_r + IW'(1);
                            if (last_bit_s) begin
                                state_r <= DRAIN;
                            end else if (word_end_s) begin
                                state_r <= FETCH;
                            end
                        end
                    end
                    DRAIN: begin
                        if (!rb_valid_s || rb_ready) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    cfg_rb_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk       (prog_clk),
        .rst       (pReset),
        .clr       (kill_s),
        .bit_valid (shift_en_s),
        .bit_in    (ccff_tail),
        .flush     (last_bit_s),
        .rb_ready  (rb_ready),
        .rb_data   (rb_data_s),
        .rb_valid  (rb_valid_s)
    );

    assign cfg_ready = cfg_ready_s;
    assign shift_en  = shift_en_s;
    assign ccff_head = head_s;
    assign rb_data   = rb_data_s;
    assign rb_valid  = rb_valid_s;
    assign busy      = busy_s;
    assign done      = done_r;
    assign aborted   = aborted_r;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader with a 20-flop behavioural chain, 8-bit words.
module tb_cfg_chain_loader;
    import cfg_chain_pkg::*;

    localparam int CL = 20;
    localparam int WW = 8;
    localparam int NW = num_words(CL, WW);

    logic          prog_clk;
    logic          pReset;
    logic          start;
    logic          abort;
    logic [WW-1:0] cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          ccff_head;
    logic          shift_en;
    logic          ccff_tail;
    logic [WW-1:0] rb_data;
    logic          rb_valid;
    logic          rb_ready;
    logic          busy;
    logic          done;
    logic          aborted;

    logic [CL-1:0] chain_m = 20'hABCDE;
    logic [6:0]    flags;
    int            checks = 0;
    int            errors = 0;

    cfg_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk (prog_clk), .pReset (pReset), .start (start), .abort (abort),
        .cfg_data (cfg_data), .cfg_valid (cfg_valid), .cfg_ready (cfg_ready),
        .ccff_head (ccff_head), .shift_en (shift_en), .ccff_tail (ccff_tail),
        .rb_data (rb_data), .rb_valid (rb_valid), .rb_ready (rb_ready),
        .busy (busy), .done (done), .aborted (aborted)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // Behavioural configuration chain: tail is the oldest bit.
    always @(posedge prog_clk) begin
        if (shift_en) chain_m <= {chain_m[CL-2:0], ccff_head};
    end
    assign ccff_tail = chain_m[CL-1];
    assign flags = {cfg_ready, shift_en, ccff_head, rb_valid, busy, done, aborted};

    typedef struct {
        logic       start;
        logic       abort;
        logic       cfg_valid;
        logic [7:0] cfg_data;
        logic       rb_ready;
        logic [6:0] exp_flags;
        logic [7:0] exp_rb;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic st, input logic ab, input logic cv, input logic [7:0] cd,
                                 input logic rr, input logic [6:0] ef, input logic [7:0] er);
        vec_t v;
        v.start = st; v.abort = ab; v.cfg_valid = cv; v.cfg_data = cd;
        v.rb_ready = rr; v.exp_flags = ef; v.exp_rb = er;
        return v;
    endfunction

    // Full load with optional FETCH gaps, readback hold and start held high throughout.
    task automatic do_load(input string tag, input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                           input int gap, input int hold, input logic keep_start,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                           input logic [CL-1:0] echain);
        logic [7:0] w [3];
        logic [7:0] e [3];
        logic [7:0] rbq[$];
        int widx = 0, sh_in_word = 0, shifts = 0, gap_cnt = 0, hold_cnt = 0;
        int last_hs = -1, done_cyc = -1, done_cnt = 0, bad_gap = 0, bad_hold = 0;
        bit hold_armed = 1'b0, finished = 1'b0;
        w[0] = w0; w[1] = w1; w[2] = w2;
        e[0] = e0; e[1] = e1; e[2] = e2;
        @(negedge prog_clk);
        start = 1'b1; abort = 1'b0; cfg_valid = 1'b0; rb_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge prog_clk);
            start = keep_start && (done_cyc < 0);
            if (rb_valid && hold > 0 && !hold_armed) begin
                hold_armed = 1'b1;
                hold_cnt   = hold;
            end
            rb_ready  = (hold_cnt == 0);
            cfg_valid = (widx < 3) && (gap_cnt == 0);
            cfg_data  = w[(widx < 3) ? widx : 0];
            #1;
            if (gap_cnt > 0 && shift_en) bad_gap++;
            if (hold_cnt > 0 && (shift_en || cfg_ready)) bad_hold++;
            if (gap_cnt > 0) gap_cnt--;
            if (hold_cnt > 0) hold_cnt--;
            if (cfg_valid && cfg_ready) begin
                widx++;
                sh_in_word = 0;
            end
            if (shift_en) begin
                shifts++;
                sh_in_word++;
                if (sh_in_word == WW && widx < 3) gap_cnt = gap;
            end
            if (rb_valid && rb_ready) begin
                rbq.push_back(rb_data);
                last_hs = cyc;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end else if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check({tag, "_idle_after_done"}, {31'd0, busy}, 32'd0);
                finished = 1'b1;
            end
        end
        start = 1'b0; cfg_valid = 1'b0; rb_ready = 1'b1;
        check({tag, "_completed"}, {31'd0, finished}, 32'd1);
        check({tag, "_shift_count"}, shifts, CL);
        check({tag, "_rb_words"}, rbq.size(), NW);
        for (int i = 0; i < 3; i++) begin
            if (i < rbq.size()) check($sformatf("%s_rb%0d", tag, i), {24'd0, rbq[i]}, {24'd0, e[i]});
        end
        check({tag, "_done_timing"}, done_cyc, last_hs + 1);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_no_shift_in_gap"}, bad_gap, 0);
        check({tag, "_no_shift_in_hold"}, bad_hold, 0);
        check({tag, "_chain"}, {12'd0, chain_m}, {12'd0, echain});
    endtask

    initial begin
        logic [7:0] words_a [3];
        logic [7:0] rb_a [3];
        logic [7:0] aw [2];
        int sh, widx, done_seen;
        words_a = '{8'hF0, 8'h0F, 8'hA5};
        rb_a    = '{8'hAB, 8'hCD, 8'hE0};
        aw      = '{8'hC3, 8'h3C};

        pReset = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
        cfg_data = 8'h00; rb_ready = 1'b1;
        repeat (2) @(negedge prog_clk);
        check("reset_flags", {25'd0, flags}, 32'd0);
        check("reset_rb_data", {24'd0, rb_data}, 32'd0);
        pReset = 1'b0;

        // Cycle-exact vectors for a stall-free load of F0, 0F, A5.
        vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 7'b0000000, 8'h00));
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mkv(1'b0, 1'b0, 1'b1, words_a[k], 1'b1,
                               (k == 0) ? 7'b1000100 : 7'b1001100, (k == 0) ? 8'h00 : rb_a[k-1]));
            for (int i = 0; i < ((k < 2) ? 8 : 4); i++) begin
                vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, {2'b01, words_a[k][7-i], 4'b0100}, 8'h00));
            end
        end
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 7'b0001100, 8'hE0));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 7'b0000110, 8'h00));
        vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 7'b0000000, 8'h00));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge prog_clk);
            start = vecs[i].start; abort = vecs[i].abort; cfg_valid = vecs[i].cfg_valid;
            cfg_data = vecs[i].cfg_data; rb_ready = vecs[i].rb_ready;
            #1;
            check($sformatf("vec%0d_flags", i), {25'd0, flags}, {25'd0, vecs[i].exp_flags});
            if (vecs[i].exp_flags[3]) check($sformatf("vec%0d_rb", i), {24'd0, rb_data}, {24'd0, vecs[i].exp_rb});
        end
        check("table_chain", {12'd0, chain_m}, {12'd0, 20'hF00FA});

        do_load("gap", 8'hF0, 8'h0F, 8'hA5, 3, 0, 1'b0, 8'hF0, 8'h0F, 8'hA0, 20'hF00FA);
        do_load("hold", 8'h12, 8'h34, 8'h56, 0, 10, 1'b0, 8'hF0, 8'h0F, 8'hA0, 20'h12345);

        // Abort after 11 shifts, then reload.
        sh = 0; widx = 0; done_seen = 0;
        @(negedge prog_clk);
        start = 1'b1; cfg_valid = 1'b0; rb_ready = 1'b1;
        for (int c = 0; c < 100 && sh < 11; c++) begin
            @(negedge prog_clk);
            start = 1'b0; cfg_valid = 1'b1; cfg_data = aw[(widx > 1) ? 1 : widx];
            #1;
            if (cfg_valid && cfg_ready) widx++;
            if (shift_en) sh++;
            if (done) done_seen++;
        end
        check("abort_shift_count", sh, 11);
        @(negedge prog_clk);
        abort = 1'b1; cfg_valid = 1'b1; cfg_data = 8'h3C;
        #1;
        check("abort_cycle_shift_en", {31'd0, shift_en}, 32'd0);
        check("abort_cycle_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        @(negedge prog_clk);
        abort = 1'b0; cfg_valid = 1'b0;
        #1;
        check("abort_pulse", {31'd0, aborted}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_rb_valid", {31'd0, rb_valid}, 32'd0);
        if (done) done_seen++;
        @(negedge prog_clk);
        #1;
        check("abort_pulse_end", {31'd0, aborted}, 32'd0);
        check("abort_no_done", done_seen + int'(done), 0);
        check("abort_chain", {12'd0, chain_m}, {12'd0, 20'hA2E19});
        do_load("reload", 8'h9A, 8'hBC, 8'hDE, 0, 0, 1'b0, 8'hA2, 8'hE1, 8'h90, 20'h9ABCD);

        do_load("start_busy", 8'h55, 8'hAA, 8'h33, 0, 0, 1'b1, 8'h9A, 8'hBC, 8'hD0, 20'h55AA3);

        // Reset in the middle of word 2.
        @(negedge prog_clk);
        start = 1'b1; cfg_valid = 1'b0; rb_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge prog_clk);
            start = 1'b0; cfg_valid = 1'b1; cfg_data = 8'h5A;
        end
        #1;
        check("pre_reset_shifting", {31'd0, shift_en}, 32'd1);
        pReset = 1'b1;
        #1;
        check("mid_reset_flags", {25'd0, flags}, 32'd0);
        check("mid_reset_rb_data", {24'd0, rb_data}, 32'd0);
        @(negedge prog_clk);
        pReset = 1'b0;
        #1;
        check("post_reset_idle", {25'd0, flags}, 32'd0);

        // start and abort together in IDLE.
        @(negedge prog_clk);
        start = 1'b1; abort = 1'b1; cfg_valid = 1'b1;
        @(negedge prog_clk);
        start = 1'b0; abort = 1'b0;
        #1;
        check("start_abort_idle_busy", {31'd0, busy}, 32'd0);
        check("start_abort_no_pulse", {31'd0, aborted}, 32'd0);
        check("start_abort_no_ready", {31'd0, cfg_ready}, 32'd0);
        cfg_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
